painter_sequencer: RTL and testbench

Scan sequencer for the painter datapath on the 64x64 LED panel. Walks x/y/frame/subframe into the pipelined painter, captures its `rgb` output after the fixed pipeline delay into a double-buffered row store, and hands completed rows to the panel driver over a ready/ack handshake. Sits between `led_main`'s panel driver and `painter`; owns the frame and subframe counters.

---
 rtl/painter_seq_pkg.sv | 23 ++
 rtl/painter_sequencer_if.sv | 30 +++
 rtl/painter_sequencer_row_buffer_2x.sv | 46 ++++
 rtl/painter_sequencer.sv | 142 ++++++++++++++
 tb/tb_painter_sequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/painter_seq_pkg.sv
// Shared types and widths for the painter scan sequencer.
package painter_seq_pkg;

    localparam int LINE_W     = 64;
    localparam int X_W        = 6;
    localparam int RGB_W      = 3;
    localparam int FRAME_W    = 10;
    localparam int SUBFRAME_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
        WAIT,
        SWAP
    } seq_state_t;

    typedef struct packed {
        logic           valid;
        logic [X_W-1:0] x;
    } cap_entry_t;

endpackage

// File: rtl/painter_sequencer_if.sv
// Painter scan bus plus panel-driver row handshake; master = sequencer side.
interface painter_sequencer_if;
    import painter_seq_pkg::*;

    logic [X_W-1:0]        p_x;
    logic [X_W-1:0]        p_y;
    logic [FRAME_W-1:0]    p_frame;
    logic [SUBFRAME_W-1:0] p_subframe;
    logic [RGB_W-1:0]      p_rgb;
    logic                  row_ready;
    logic                  row_ack;
    logic [X_W-1:0]        row_y;
    logic [X_W-1:0]        rd_addr;
    logic [RGB_W-1:0]      rd_rgb;

    modport master (
        output p_x, p_y, p_frame, p_subframe,
        input  p_rgb,
        output row_ready, row_y, rd_rgb,
        input  row_ack, rd_addr
    );

    modport slave (
        input  p_x, p_y, p_frame, p_subframe,
        output p_rgb,
        input  row_ready, row_y, rd_rgb,
        output row_ack, rd_addr
    );

endinterface

// File: rtl/painter_sequencer_row_buffer_2x.sv
// Two 64x3 row banks: back bank written by capture, front bank read (registered) by the driver.
module row_buffer_2x
    import painter_seq_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             swap,
    input  logic             wr_en,
    input  logic [X_W-1:0]   wr_addr,
    input  logic [RGB_W-1:0] wr_data,
    input  logic [X_W-1:0]   rd_addr,
    output logic [RGB_W-1:0] rd_data
);

    logic [RGB_W-1:0] bank0 [LINE_W];
    logic [RGB_W-1:0] bank1 [LINE_W];
    logic             front_sel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            front_sel <= 1'b0;
        end else if (swap) begin
            front_sel <= ~front_sel;
        end
    end

    // front_sel=0: bank0 is front, bank1 is back
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (front_sel) begin
                bank0[wr_addr] <= wr_data;
            end else begin
                bank1[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data <= '0;
        end else begin
            rd_data <= front_sel ? bank1[rd_addr] : bank0[rd_addr];
        end
    end

endmodule

// File: rtl/painter_sequencer.sv
// Scan sequencer: walks x/y/frame/subframe into the painter and double-buffers captured rows.
// Optional stall counter enabled by defining PAINTER_SEQ_STALL_EN.
module painter_sequencer
    import painter_seq_pkg::*;
#(
    parameter int DELAY     = 3,
    parameter int SUBFRAMES = 256
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                run,
    painter_sequencer_if.master bus
`ifdef PAINTER_SEQ_STALL_EN
    ,
    output logic [15:0]         stall_count
`endif
);

    // state | meaning
    // IDLE  | halted, waiting for run
    // FILL  | issuing p_x 0..63 for row p_y
    // DRAIN | waiting DELAY cycles for the last capture to land
    // WAIT  | back row complete, driver still owns the front row
    // SWAP  | exchange banks, publish row, advance counters

    seq_state_t            state, state_nxt;
    logic [X_W-1:0]        x_q, y_q, row_y_q;
    logic [FRAME_W-1:0]    frame_q;
    logic [SUBFRAME_W-1:0] sub_q;
    logic                  row_ready_q;
    logic [2:0]            drain_cnt;
    logic                  swap;
    logic [RGB_W-1:0]      rd_rgb_w;
    cap_entry_t            cap_pipe [DELAY];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        swap      = 1'b0;
        case (state)
            IDLE:    if (run) state_nxt = FILL;
            FILL:    if (x_q == X_W'(LINE_W - 1)) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == '0) state_nxt = row_ready_q ? WAIT : SWAP;
            WAIT:    if (!row_ready_q) state_nxt = SWAP;
            SWAP: begin
                swap      = 1'b1;
                state_nxt = run ? FILL : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // x wraps 63 -> 0 on the last FILL cycle, so it rests at 0 outside FILL
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q       <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == FILL) begin
                x_q       <= x_q + 1'b1;
                drain_cnt <= 3'(DELAY - 1);
            end else if (state == DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            y_q         <= '0;
            sub_q       <= '0;
            frame_q     <= '0;
            row_y_q     <= '0;
            row_ready_q <= 1'b0;
        end else begin
            if (swap) begin
                row_ready_q <= 1'b1;
                row_y_q     <= y_q;
                if (y_q == X_W'(LINE_W - 1)) begin
                    y_q <= '0;
                    if (sub_q == SUBFRAME_W'(SUBFRAMES - 1)) begin
                        sub_q   <= '0;
                        frame_q <= frame_q + 1'b1;
                    end else begin
                        sub_q <= sub_q + 1'b1;
                    end
                end else begin
                    y_q <= y_q + 1'b1;
                end
            end else if (bus.row_ack) begin
                row_ready_q <= 1'b0;
            end
        end
    end

    // capture pipe tracks which x the painter output belongs to
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DELAY; i++) cap_pipe[i] <= '0;
        end else begin
            cap_pipe[0] <= '{valid: (state == FILL), x: x_q};
            for (int i = 1; i < DELAY; i++) cap_pipe[i] <= cap_pipe[i-1];
        end
    end

`ifdef PAINTER_SEQ_STALL_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_count <= '0;
        end else if (state == WAIT && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`endif

    row_buffer_2x u_rows (
        .clk     (clk),
        .resetn  (resetn),
        .swap    (swap),
        .wr_en   (cap_pipe[DELAY-1].valid),
        .wr_addr (cap_pipe[DELAY-1].x),
        .wr_data (bus.p_rgb),
        .rd_addr (bus.rd_addr),
        .rd_data (rd_rgb_w)
    );

    assign bus.p_x        = x_q;
    assign bus.p_y        = y_q;
    assign bus.p_frame    = frame_q;
    assign bus.p_subframe = sub_q;
    assign bus.row_ready  = row_ready_q;
    assign bus.row_y      = row_y_q;
    assign bus.rd_rgb     = rd_rgb_w;

endmodule

// File: tb/tb_painter_sequencer.sv
// Self-checking bench for painter_sequencer: painter model, row-level reference and driver tasks.
module tb_painter_sequencer;
    import painter_seq_pkg::*;

    localparam int DELAY      = 3;
    localparam int SUBFRAMES  = 256;
    localparam int DELAY2     = 1;
    localparam int SUBFRAMES2 = 2;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        run    = 1'b0;
    logic        run2   = 1'b0;
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          paint_mode = 1'b0;
    int unsigned key = 0;
`ifdef PAINTER_SEQ_STALL_EN
    logic [15:0] stall_count;
    logic [15:0] stall_count2;
`endif

    painter_sequencer_if bus ();
    painter_sequencer_if bus2 ();

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    painter_sequencer #(.DELAY(DELAY), .SUBFRAMES(SUBFRAMES)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .run    (run),
        .bus    (bus)
`ifdef PAINTER_SEQ_STALL_EN
        ,
        .stall_count (stall_count)
`endif
    );

    painter_sequencer #(.DELAY(DELAY2), .SUBFRAMES(SUBFRAMES2)) u_dut2 (
        .clk    (clk),
        .resetn (resetn),
        .run    (run2),
        .bus    (bus2)
`ifdef PAINTER_SEQ_STALL_EN
        ,
        .stall_count (stall_count2)
`endif
    );

    // painter: pure function of its inputs, DELAY register stages deep
    function automatic logic [2:0] paint(input int x, input int y, input int fr, input int sf);
        int unsigned h;
        if (!paint_mode) h = x;
        else h = x * 5 + y * 3 + fr * 7 + sf * 11 + key + (x / 8) * y;
        return h[2:0];
    endfunction

    logic [2:0] ppipe [DELAY];
    always @(posedge clk) begin
        ppipe[0] <= paint(int'(bus.p_x), int'(bus.p_y), int'(bus.p_frame), int'(bus.p_subframe));
        for (int i = 1; i < DELAY; i++) ppipe[i] <= ppipe[i-1];
    end
    assign bus.p_rgb  = ppipe[DELAY-1];
    assign bus2.p_rgb = 3'b101;

    // expected pixel k of the n-th row delivered since reset
    function automatic logic [2:0] row_pixel(input int n, input int k);
        return paint(k, n % 64, (n / (64 * SUBFRAMES)) % 1024, (n / 64) % SUBFRAMES);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        run = 1'b0;
        bus.row_ack = 1'b0;
        bus.rd_addr = '0;
        resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        step();
    endtask

    task automatic wait_ready(input string name, input int budget);
        int n;
        n = 0;
        while (bus.row_ready !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (bus.row_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s: row_ready=%b after %0d cycles, required 1", name, bus.row_ready, budget);
        end
    endtask

    // called on the cycle row n becomes ready; counters already advanced past row n
    task automatic read_row(input int n);
        int order [64];
        int j, t;
        checks++;
        if (bus.row_y !== 6'(n % 64)) begin
            failures++;
            $display("FAIL row_y: got %0d required %0d", bus.row_y, n % 64);
        end
        checks++;
        if (bus.p_y !== 6'((n + 1) % 64)) begin
            failures++;
            $display("FAIL p_y: got %0d required %0d", bus.p_y, (n + 1) % 64);
        end
        checks++;
        if (bus.p_subframe !== 8'(((n + 1) / 64) % SUBFRAMES)) begin
            failures++;
            $display("FAIL p_subframe: got %0d required %0d", bus.p_subframe, ((n + 1) / 64) % SUBFRAMES);
        end
        checks++;
        if (bus.p_frame !== 10'(((n + 1) / (64 * SUBFRAMES)) % 1024)) begin
            failures++;
            $display("FAIL p_frame: got %0d required %0d", bus.p_frame, ((n + 1) / (64 * SUBFRAMES)) % 1024);
        end
        for (int i = 0; i < 64; i++) order[i] = i;
        for (int i = 63; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 64; i++) begin
            bus.rd_addr = 6'(order[i]);
            step();
            checks++;
            if (bus.rd_rgb !== row_pixel(n, order[i])) begin
                failures++;
                $display("FAIL rd_rgb row %0d col %0d: got %0d required %0d", n, order[i], bus.rd_rgb, row_pixel(n, order[i]));
            end
        end
    endtask

    task automatic ack_row();
        bus.row_ack = 1'b1;
        step();
        bus.row_ack = 1'b0;
        checks++;
        if (bus.row_ready !== 1'b0) begin
            failures++;
            $display("FAIL ack_clear: row_ready=%b required 0", bus.row_ready);
        end
    endtask

    task automatic test_reset();
        run = 1'b0;
        bus.row_ack = 1'b0;
        bus.rd_addr = '0;
        resetn = 1'b0;
        step();
        step();
        checks++;
        if ({bus.p_x, bus.p_y, bus.p_frame, bus.p_subframe} !== 30'd0) begin
            failures++;
            $display("FAIL reset_counters: x=%0d y=%0d fr=%0d sf=%0d required 0", bus.p_x, bus.p_y, bus.p_frame, bus.p_subframe);
        end
        checks++;
        if ({bus.row_ready, bus.row_y, bus.rd_rgb} !== 10'd0) begin
            failures++;
            $display("FAIL reset_row: ready=%b row_y=%0d rd_rgb=%0d required 0", bus.row_ready, bus.row_y, bus.rd_rgb);
        end
`ifdef PAINTER_SEQ_STALL_EN
        checks++;
        if (stall_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_stall: got %0d required 0", stall_count);
        end
`endif
        resetn = 1'b1;
        repeat (10) step();
        checks++;
        if (bus.row_ready !== 1'b0 || bus.p_x !== 6'd0) begin
            failures++;
            $display("FAIL idle_hold: ready=%b x=%0d required 0/0", bus.row_ready, bus.p_x);
        end
    endtask

    task automatic test_first_row();
        logic exp_ready;
        do_reset();
        paint_mode = 1'b0;
        run = 1'b1;
        for (int n = 1; n <= 66 + DELAY; n++) begin
            step();
            if (n <= 64) begin
                checks++;
                if (bus.p_x !== 6'(n - 1)) begin
                    failures++;
                    $display("FAIL fill_x step %0d: got %0d required %0d", n, bus.p_x, n - 1);
                end
            end
            if (n >= 60) begin
                exp_ready = (n == 66 + DELAY);
                checks++;
                if (bus.row_ready !== exp_ready) begin
                    failures++;
                    $display("FAIL first_ready step %0d: got %b required %b", n, bus.row_ready, exp_ready);
                end
            end
        end
        read_row(0);
        ack_row();
    endtask

    task automatic test_rows_in_order();
        do_reset();
        paint_mode = 1'b1;
        key = $urandom;
        run = 1'b1;
        for (int n = 0; n < 64; n++) begin
            wait_ready("row_in_order", 400);
            read_row(n);
            repeat ($urandom_range(20, 0)) step();
            ack_row();
        end
    endtask

    task automatic test_stall();
        int r0, k;
        do_reset();
        key = $urandom;
        run = 1'b1;
        wait_ready("stall_row0", 200);
        r0 = cyc;
        read_row(0);
        while (cyc < r0 + 199) begin
            k = int'($urandom_range(63, 0));
            bus.rd_addr = 6'(k);
            step();
            checks++;
            if (bus.rd_rgb !== row_pixel(0, k)) begin
                failures++;
                $display("FAIL front_held col %0d: got %0d required %0d", k, bus.rd_rgb, row_pixel(0, k));
            end
        end
        checks++;
        if (bus.p_y !== 6'd1) begin
            failures++;
            $display("FAIL wait_no_swap: p_y=%0d required 1", bus.p_y);
        end
        ack_row();
        step();
        checks++;
        if (bus.row_ready !== 1'b0) begin
            failures++;
            $display("FAIL swap_latency_a: ready=%b required 0", bus.row_ready);
        end
        step();
        checks++;
        if (bus.row_ready !== 1'b1) begin
            failures++;
            $display("FAIL swap_latency_b: ready=%b required 1", bus.row_ready);
        end
`ifdef PAINTER_SEQ_STALL_EN
        // WAIT spans from row 1 complete (r0+64+DELAY) to the cycle ready drops (r0+200)
        checks++;
        if (stall_count !== 16'(200 - (64 + DELAY) + 1)) begin
            failures++;
            $display("FAIL stall_count: got %0d required %0d", stall_count, 200 - (64 + DELAY) + 1);
        end
`endif
        read_row(1);
        ack_row();
    endtask

    task automatic test_reset_mid_row();
        int w;
        do_reset();
        key = $urandom;
        run = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wait_ready("pre_reset_row", 400);
            read_row(n);
            ack_row();
        end
        wait_ready("row4", 400);
        w = 0;
        while (!(bus.p_y == 6'd5 && bus.p_x == 6'd30) && w < 200) begin
            step();
            w++;
        end
        checks++;
        if (bus.p_y !== 6'd5 || bus.p_x !== 6'd30) begin
            failures++;
            $display("FAIL reach_x30: y=%0d x=%0d required 5/30", bus.p_y, bus.p_x);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({bus.p_x, bus.p_y, bus.p_subframe, bus.row_ready, bus.row_y, bus.rd_rgb} !== 30'd0) begin
            failures++;
            $display("FAIL async_reset: x=%0d y=%0d sf=%0d ready=%b row_y=%0d rd=%0d required 0",
                     bus.p_x, bus.p_y, bus.p_subframe, bus.row_ready, bus.row_y, bus.rd_rgb);
        end
        step();
        resetn = 1'b1;
        wait_ready("after_reset", 200);
        read_row(0);
        ack_row();
    endtask

    task automatic test_run_drop();
        int w;
        do_reset();
        key = $urandom;
        run = 1'b1;
        w = 0;
        while (bus.p_x != 6'd20 && w < 100) begin
            step();
            w++;
        end
        run = 1'b0;
        wait_ready("run_drop_row", 200);
        read_row(0);
        ack_row();
        for (int n = 0; n < 150; n++) begin
            step();
            checks++;
            if (bus.p_x !== 6'd0 || bus.row_ready !== 1'b0) begin
                failures++;
                $display("FAIL halted cycle %0d: x=%0d ready=%b required 0/0", n, bus.p_x, bus.row_ready);
            end
        end
        checks++;
        if (bus.p_y !== 6'd1) begin
            failures++;
            $display("FAIL halted_y: got %0d required 1", bus.p_y);
        end
    endtask

    task automatic test_subframe_wrap();
        int prev, w;
        prev = 0;
        run2 = 1'b1;
        for (int n = 0; n < 128; n++) begin
            w = 0;
            while (bus2.row_ready !== 1'b1 && w < 300) begin
                step();
                w++;
            end
            checks++;
            if (bus2.row_ready !== 1'b1 || bus2.row_y !== 6'(n % 64)) begin
                failures++;
                $display("FAIL sf2_row %0d: ready=%b row_y=%0d required 1/%0d", n, bus2.row_ready, bus2.row_y, n % 64);
            end
            if (n > 0) begin
                checks++;
                if (cyc - prev != 65 + DELAY2) begin
                    failures++;
                    $display("FAIL row_period: got %0d required %0d", cyc - prev, 65 + DELAY2);
                end
            end
            prev = cyc;
            bus2.row_ack = 1'b1;
            step();
            bus2.row_ack = 1'b0;
        end
        checks++;
        if (bus2.p_frame !== 10'd1 || bus2.p_subframe !== 8'd0 || bus2.p_y !== 6'd0) begin
            failures++;
            $display("FAIL frame_wrap: fr=%0d sf=%0d y=%0d required 1/0/0", bus2.p_frame, bus2.p_subframe, bus2.p_y);
        end
        run2 = 1'b0;
    endtask

    initial begin
        bus.row_ack  = 1'b0;
        bus.rd_addr  = '0;
        bus2.row_ack = 1'b0;
        bus2.rd_addr = '0;
        test_reset();
        test_first_row();
        test_rows_in_order();
        test_stall();
        test_reset_mid_row();
        test_run_drop();
        test_subframe_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
